// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default bit timing and line levels.
// Used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // 25 MHz system clock at 115200 baud.
    localparam int UART_CLKS_PER_BIT          = 217;
    localparam int UART_CLKS_PER_BIT_OVER_TWO = 108;

    localparam logic IDLE_LINE = 1'b1;

endpackage

// File: rtl/uart_tx_if.sv
// Byte-producer to UART transmitter handshake plus status and serial line.
// The producer (master) offers bytes; the transmitter (slave) accepts them.
interface uart_tx_if;

    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       tx_ready;
    logic       tx_active;
    logic       tx_done;
    logic       uart_tx;

    modport master (
        output tx_dv,
        output tx_byte,
        input  tx_ready,
        input  tx_active,
        input  tx_done,
        input  uart_tx
    );

    modport slave (
        input  tx_dv,
        input  tx_byte,
        output tx_ready,
        output tx_active,
        output tx_done,
        output uart_tx
    );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period timer: one-cycle tick on the last cycle of every CLKS_PER_BIT period.
// Holding clear keeps the period phase at zero so the next period starts aligned.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = ~clear & (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte intake, 8-N-1 (or 8-x-1/2) frame on o_UART_TX.
// Define UART_TX_PARITY_EN to insert a parity bit between the data and stop bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_TX_DV,
    input  logic [7:0] i_TX_Byte,
    output logic       o_TX_Ready,
    output logic       o_TX_Active,
    output logic       o_TX_Done,
    output logic       o_UART_TX
);

    localparam logic LAST_STOP = 1'(STOP_BITS - 1);

    uart_state_e state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        stop_idx_q, stop_idx_d;
    logic        tx_q, tx_d;
    logic        ready_q, ready_d;
    logic        active_q, active_d;
    logic        done_q, done_d;
    logic        bit_tick;
    logic        baud_clear;

`ifdef UART_TX_PARITY_EN
    logic parity_q, parity_d;
`else
    localparam bit unused_parity_odd = PARITY_ODD[0];
`endif

    // Timer sits at phase zero while idle so the start bit gets a full period.
    assign baud_clear = (state_q == IDLE);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk   (i_Clk),
        .rst_n (i_Rst_L),
        .clear (baud_clear),
        .tick  (bit_tick)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        tx_d       = tx_q;
        ready_d    = ready_q;
        active_d   = active_q;
        done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif

        case (state_q)
            IDLE: begin
                tx_d     = IDLE_LINE;
                ready_d  = 1'b1;
                active_d = 1'b0;
                if (i_TX_DV) begin
                    state_d    = START;
                    shift_d    = i_TX_Byte;
                    bit_idx_d  = 3'd0;
                    stop_idx_d = 1'b0;
                    tx_d       = 1'b0;
                    ready_d    = 1'b0;
                    active_d   = 1'b1;
`ifdef UART_TX_PARITY_EN
                    parity_d   = (^i_TX_Byte) ^ PARITY_ODD[0];
`endif
                end
            end

            START: begin
                if (bit_tick) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                end
            end

            // shift_q[0] always holds the bit that goes out at the next boundary.
            DATA: begin
                if (bit_tick) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = parity_q;
`else
                        state_d = STOP;
                        tx_d    = IDLE_LINE;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_tick) begin
                    state_d = STOP;
                    tx_d    = IDLE_LINE;
                end
            end
`endif

            STOP: begin
                if (bit_tick) begin
                    if (stop_idx_q == LAST_STOP) begin
                        state_d  = IDLE;
                        done_d   = 1'b1;
                        ready_d  = 1'b1;
                        active_d = 1'b0;
                    end else begin
                        stop_idx_d = stop_idx_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d  = IDLE;
                tx_d     = IDLE_LINE;
                ready_d  = 1'b1;
                active_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            tx_q       <= IDLE_LINE;
            ready_q    <= 1'b1;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            tx_q       <= tx_d;
            ready_q    <= ready_d;
            active_q   <= active_d;
            done_q     <= done_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    assign o_UART_TX   = tx_q;
    assign o_TX_Ready  = ready_q;
    assign o_TX_Active = active_q;
    assign o_TX_Done   = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: idle, framing, back-to-back, mid-frame reset, default timing.
// With UART_TX_PARITY_EN defined the frames carry a parity bit and an odd-parity DUT is added.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int CPB = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    uart_tx_if if_a ();
    uart_tx_if if_c ();

    uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(0)) dut_a (
        .i_Clk       (clk),
        .i_Rst_L     (rst_n),
        .i_TX_DV     (if_a.tx_dv),
        .i_TX_Byte   (if_a.tx_byte),
        .o_TX_Ready  (if_a.tx_ready),
        .o_TX_Active (if_a.tx_active),
        .o_TX_Done   (if_a.tx_done),
        .o_UART_TX   (if_a.uart_tx)
    );

    uart_tx dut_c (
        .i_Clk       (clk),
        .i_Rst_L     (rst_n),
        .i_TX_DV     (if_c.tx_dv),
        .i_TX_Byte   (if_c.tx_byte),
        .o_TX_Ready  (if_c.tx_ready),
        .o_TX_Active (if_c.tx_active),
        .o_TX_Done   (if_c.tx_done),
        .o_UART_TX   (if_c.uart_tx)
    );

`ifdef UART_TX_PARITY_EN
    uart_tx_if if_o ();

    uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(1)) dut_o (
        .i_Clk       (clk),
        .i_Rst_L     (rst_n),
        .i_TX_DV     (if_o.tx_dv),
        .i_TX_Byte   (if_o.tx_byte),
        .o_TX_Ready  (if_o.tx_ready),
        .o_TX_Active (if_o.tx_active),
        .o_TX_Done   (if_o.tx_done),
        .o_UART_TX   (if_o.uart_tx)
    );
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {line, ready, active, done} of the selected instance.
    function automatic logic [3:0] outs(input int s);
        case (s)
            0: return {if_a.uart_tx, if_a.tx_ready, if_a.tx_active, if_a.tx_done};
`ifdef UART_TX_PARITY_EN
            2: return {if_o.uart_tx, if_o.tx_ready, if_o.tx_active, if_o.tx_done};
`endif
            default: return {if_c.uart_tx, if_c.tx_ready, if_c.tx_active, if_c.tx_done};
        endcase
    endfunction

    task automatic drive(input int s, input logic dv, input logic [7:0] b);
        case (s)
            0: begin if_a.tx_dv = dv; if_a.tx_byte = b; end
`ifdef UART_TX_PARITY_EN
            2: begin if_o.tx_dv = dv; if_o.tx_byte = b; end
`endif
            default: begin if_c.tx_dv = dv; if_c.tx_byte = b; end
        endcase
    endtask

    // Entered on the first start-bit cycle; returns on the o_TX_Done cycle.
    task automatic check_frame(input int s, input logic [7:0] b, input int cpb,
                               input logic par, input string tag);
        logic [10:0] bits;
        logic [7:0]  cap;
        logic [3:0]  o;
        int          nb;
        int          bad_ctl;
        int          done_seen;
        int          mism;
`ifdef UART_TX_PARITY_EN
        bits = {1'b1, par, b, 1'b0};
        nb   = 11;
`else
        bits = {1'b0, 1'b1, b, 1'b0};
        nb   = 10;
`endif
        cap       = '0;
        bad_ctl   = 0;
        done_seen = 0;
        for (int k = 0; k < nb; k++) begin
            mism = 0;
            for (int c = 0; c < cpb; c++) begin
                o = outs(s);
                if (o[3] !== bits[k]) mism++;
                if (o[2] !== 1'b0 || o[1] !== 1'b1) bad_ctl++;
                if (o[0] !== 1'b0) done_seen++;
                if (c == cpb / 2 && k >= 1 && k <= 8) cap[k-1] = o[3];
                step();
            end
            check($sformatf("%s bit%0d wrong-cycles", tag, k), mism, 0);
        end
        check($sformatf("%s ready/active during frame", tag), bad_ctl, 0);
        check($sformatf("%s early done", tag), done_seen, 0);
        check($sformatf("%s mid-bit capture", tag), cap, b);
        check($sformatf("%s done cycle {tx,rdy,act,done}", tag), outs(s), 4'b1101);
    endtask

    initial begin
        int lows;
        int dones;

        rst_n = 1'b0;
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
`ifdef UART_TX_PARITY_EN
        drive(2, 1'b0, 8'h00);
`endif
        repeat (3) step();
        check("in reset a", outs(0), 4'b1100);
        check("in reset c", outs(1), 4'b1100);
        rst_n = 1'b1;

        // Idle 50 cycles.
        lows  = 0;
        dones = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (outs(0) !== 4'b1100) lows++;
            if (if_a.tx_done !== 1'b0) dones++;
        end
        check("idle outputs deviations", lows, 0);
        check("idle done pulses", dones, 0);

        // 0xA3: bits 1,1,0,0,0,1,0,1.
        drive(0, 1'b1, 8'hA3);
        step();
        drive(0, 1'b0, 8'h00);
        check_frame(0, 8'hA3, CPB, 1'b0, "A3");
        step();
        check("A3 post-done", outs(0), 4'b1100);

        // 0x55 with DV held high offering 0x0F; 0x0F taken in the done cycle.
        repeat (4) step();
        drive(0, 1'b1, 8'h55);
        step();
        drive(0, 1'b1, 8'h0F);
        check_frame(0, 8'h55, CPB, 1'b0, "55");
        step();
        drive(0, 1'b0, 8'h00);
        check("0F start right after done", outs(0), 4'b0010);
        check_frame(0, 8'h0F, CPB, 1'b0, "0F");
        step();
        check("0F post-done", outs(0), 4'b1100);

        // Reset during data bit 3 of 0xFF (cycles 32..39 of the frame).
        repeat (3) step();
        drive(0, 1'b1, 8'hFF);
        step();
        drive(0, 1'b0, 8'h00);
        repeat (35) step();
        check("FF bit3 before reset", outs(0), 4'b1010);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset outputs", outs(0), 4'b1100);
        repeat (3) step();
        #2;
        rst_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (outs(0) !== 4'b1100) lows++;
        end
        check("no resume after reset", lows, 0);
        drive(0, 1'b1, 8'h00);
        step();
        drive(0, 1'b0, 8'h00);
        check_frame(0, 8'h00, CPB, 1'b0, "00");
        step();

`ifdef UART_TX_PARITY_EN
        // 0x07 has three ones: even parity bit 1, odd parity bit 0.
        drive(0, 1'b1, 8'h07);
        step();
        drive(0, 1'b0, 8'h00);
        check_frame(0, 8'h07, CPB, 1'b1, "07 even");
        step();
        drive(2, 1'b1, 8'h07);
        step();
        drive(2, 1'b0, 8'h00);
        check_frame(2, 8'h07, CPB, 1'b0, "07 odd");
        step();
`endif

        // Default timing, 217 cycles per bit; 0x41 has even weight so parity is 0.
        drive(1, 1'b1, 8'h41);
        step();
        drive(1, 1'b0, 8'h00);
        check_frame(1, 8'h41, UART_CLKS_PER_BIT, 1'b0, "41 default");
        step();
        check("41 post-done", outs(1), 4'b1100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
